// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if
// Bundles the three buses around the main-RAM arbiter:
//   cpu_*  : T80 slot-3 RAM request/ack path (req/we/addr/din in, dout/ack out)
//   dl_*   : ioctl download writer (wr/addr/din in, dl_wait back-pressure out)
//   mem_*  : registered spram port (addr/we/wdata out, rdata in)
//   err_overrun : sticky protocol-violation flag
// slave  = arbiter view, master = environment (CPU, loader, RAM) view.
interface ram_arbiter_if #(
    parameter int AW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_din;
    logic [7:0]    cpu_dout;
    logic          cpu_ack;

    logic          dl_wr;
    logic [AW-1:0] dl_addr;
    logic [7:0]    dl_din;
    logic          dl_wait;

    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    logic          err_overrun;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_din,
        output cpu_dout, cpu_ack,
        input  dl_wr, dl_addr, dl_din,
        output dl_wait,
        output mem_addr, mem_we, mem_wdata,
        input  mem_rdata,
        output err_overrun
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_din,
        input  cpu_dout, cpu_ack,
        output dl_wr, dl_addr, dl_din,
        input  dl_wait,
        input  mem_addr, mem_we, mem_wdata,
        output mem_rdata,
        input  err_overrun
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one synchronous single-port RAM (1-cycle read latency) between the
// CPU RAM path and the ioctl download writer. CPU has priority; a starvation
// counter forces a pending download through after STARVE_LIMIT deferred cycles.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : ram_arbiter_if.slave (CPU, download and RAM buses, overrun flag)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | arbitrating every cycle; grants CPU or download
// CPU_ACC  | CPU address/we on the RAM port this cycle
// CPU_DATA | RAM q valid; capture read data, ack issued next cycle
// DL_ACC   | download byte being written this cycle
module ram_arbiter #(
    parameter int AW           = 16,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] CPU_ACC  = 2'd1;
    localparam logic [1:0] CPU_DATA = 2'd2;
    localparam logic [1:0] DL_ACC   = 2'd3;

    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic [1:0]    state_q, state_d;
    logic          cpu_pend_q, cpu_pend_d;
    logic          pend_we_q, pend_we_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic [7:0]    pend_din_q, pend_din_d;
    logic          acc_we_q, acc_we_d;
    logic          dl_full_q, dl_full_d;
    logic [AW-1:0] dl_addr_q, dl_addr_d;
    logic [7:0]    dl_din_q, dl_din_d;
    logic [7:0]    starve_cnt_q, starve_cnt_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [7:0]    mem_wdata_q, mem_wdata_d;
    logic          err_q, err_d;

    logic cpu_src;
    logic cpu_grant;
    logic dl_grant;
    logic cpu_busy;

    always_comb begin
        state_d      = state_q;
        cpu_pend_d   = cpu_pend_q;
        pend_we_d    = pend_we_q;
        pend_addr_d  = pend_addr_q;
        pend_din_d   = pend_din_q;
        acc_we_d     = acc_we_q;
        dl_full_d    = dl_full_q;
        dl_addr_d    = dl_addr_q;
        dl_din_d     = dl_din_q;
        starve_cnt_d = starve_cnt_q;
        cpu_ack_d    = 1'b0;
        cpu_dout_d   = cpu_dout_q;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = 1'b0;
        mem_wdata_d  = mem_wdata_q;
        err_d        = err_q;

        cpu_src   = bus.cpu_req || cpu_pend_q;
        cpu_grant = 1'b0;
        dl_grant  = 1'b0;
        if (state_q == IDLE) begin
            if (dl_full_q && (starve_cnt_q == LIMIT)) begin
                dl_grant = 1'b1;
            end else if (cpu_src) begin
                cpu_grant = 1'b1;
            end else if (dl_full_q) begin
                dl_grant = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (cpu_grant) begin
                    // A latched request is older than any live strobe, so it wins.
                    if (cpu_pend_q) begin
                        mem_addr_d  = pend_addr_q;
                        mem_we_d    = pend_we_q;
                        mem_wdata_d = pend_din_q;
                        acc_we_d    = pend_we_q;
                    end else begin
                        mem_addr_d  = bus.cpu_addr;
                        mem_we_d    = bus.cpu_we;
                        mem_wdata_d = bus.cpu_din;
                        acc_we_d    = bus.cpu_we;
                    end
                    state_d = CPU_ACC;
                end else if (dl_grant) begin
                    mem_addr_d  = dl_addr_q;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = dl_din_q;
                    state_d     = DL_ACC;
                end
            end
            CPU_ACC: state_d = CPU_DATA;
            CPU_DATA: begin
                cpu_ack_d = 1'b1;
                if (!acc_we_q) begin
                    cpu_dout_d = bus.mem_rdata;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Only one CPU access may be outstanding: latched or in flight.
        cpu_busy = cpu_pend_q || (state_q == CPU_ACC) || (state_q == CPU_DATA);
        if (cpu_grant) begin
            cpu_pend_d = 1'b0;
        end
        if (bus.cpu_req) begin
            if (cpu_busy) begin
                err_d = 1'b1;
            end else if (!cpu_grant) begin
                cpu_pend_d  = 1'b1;
                pend_we_d   = bus.cpu_we;
                pend_addr_d = bus.cpu_addr;
                pend_din_d  = bus.cpu_din;
            end
        end

        // The grant cycle frees the holding register, so a strobe there refills it.
        if (dl_grant) begin
            dl_full_d = 1'b0;
        end
        if (bus.dl_wr) begin
            if (!dl_full_q || dl_grant) begin
                dl_full_d = 1'b1;
                dl_addr_d = bus.dl_addr;
                dl_din_d  = bus.dl_din;
            end else begin
                err_d = 1'b1;
            end
        end

        if (!dl_full_q || dl_grant) begin
            starve_cnt_d = 8'd0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cpu_pend_q   <= 1'b0;
            pend_we_q    <= 1'b0;
            pend_addr_q  <= '0;
            pend_din_q   <= 8'h00;
            acc_we_q     <= 1'b0;
            dl_full_q    <= 1'b0;
            dl_addr_q    <= '0;
            dl_din_q     <= 8'h00;
            starve_cnt_q <= 8'd0;
            cpu_ack_q    <= 1'b0;
            cpu_dout_q   <= 8'hFF;
            mem_addr_q   <= '0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 8'h00;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_pend_q   <= cpu_pend_d;
            pend_we_q    <= pend_we_d;
            pend_addr_q  <= pend_addr_d;
            pend_din_q   <= pend_din_d;
            acc_we_q     <= acc_we_d;
            dl_full_q    <= dl_full_d;
            dl_addr_q    <= dl_addr_d;
            dl_din_q     <= dl_din_d;
            starve_cnt_q <= starve_cnt_d;
            cpu_ack_q    <= cpu_ack_d;
            cpu_dout_q   <= cpu_dout_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.cpu_dout    = cpu_dout_q;
    assign bus.cpu_ack     = cpu_ack_q;
    assign bus.dl_wait     = dl_full_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.err_overrun = err_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Directed bench for ram_arbiter with a behavioural 64 KiB spram model.
module tb_ram_arbiter;
    logic clk;
    logic reset;
    logic ram_clr;
    int   n_checks;
    int   n_fail;

    logic [7:0] ram [0:65535];

    ram_arbiter_if #(.AW(16)) bus ();

    ram_arbiter #(.AW(16), .STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 65536; i++) ram[i] <= 8'h00;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; strobes last exactly one cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.cpu_req = 1'b0;
        bus.dl_wr   = 1'b0;
    endtask

    task automatic cpu_set(input logic we, input logic [15:0] a, input logic [7:0] d);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = we;
        bus.cpu_addr = a;
        bus.cpu_din  = d;
    endtask

    task automatic dl_set(input logic [15:0] a, input logic [7:0] d);
        bus.dl_wr   = 1'b1;
        bus.dl_addr = a;
        bus.dl_din  = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_din = 8'h0;
        bus.dl_wr = 1'b0; bus.dl_addr = 16'h0; bus.dl_din = 8'h0;
        reset   = 1'b1;
        ram_clr = 1'b1;
        tick(); tick();
        ram_clr = 1'b0;
        check("rst_ack", bus.cpu_ack, 0);
        check("rst_dout", bus.cpu_dout, 8'hFF);
        check("rst_wait", bus.dl_wait, 0);
        check("rst_we", bus.mem_we, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        check("rst_err", bus.err_overrun, 0);
        reset = 1'b0;
        tick();

        // CPU write 0x5A to 0x8000, then read it back
        cpu_set(1'b1, 16'h8000, 8'h5A); tick();
        check("wr_we", bus.mem_we, 1);
        check("wr_addr", bus.mem_addr, 16'h8000);
        check("wr_wdata", bus.mem_wdata, 8'h5A);
        check("wr_ack_c1", bus.cpu_ack, 0);
        tick();
        check("wr_we_c2", bus.mem_we, 0);
        tick();
        check("wr_ack_c3", bus.cpu_ack, 1);
        check("wr_dout_kept", bus.cpu_dout, 8'hFF);
        cpu_set(1'b0, 16'h8000, 8'h00); tick();
        check("rd_we", bus.mem_we, 0);
        check("rd_addr", bus.mem_addr, 16'h8000);
        check("rd_ack_c1", bus.cpu_ack, 0);
        tick(); tick();
        check("rd_ack_c3", bus.cpu_ack, 1);
        check("rd_dout", bus.cpu_dout, 8'h5A);

        // Uncontended download
        dl_set(16'h0123, 8'hC3); tick();
        check("dl_wait_c1", bus.dl_wait, 1);
        check("dl_we_c1", bus.mem_we, 0);
        check("dl_ack_c1", bus.cpu_ack, 0);
        tick();
        check("dl_wait_c2", bus.dl_wait, 0);
        check("dl_we_c2", bus.mem_we, 1);
        check("dl_addr", bus.mem_addr, 16'h0123);
        check("dl_wdata", bus.mem_wdata, 8'hC3);
        check("dl_err", bus.err_overrun, 0);
        tick();
        check("dl_we_c3", bus.mem_we, 0);

        // CPU and pending download in the same IDLE cycle: CPU first
        dl_set(16'h0200, 8'h77); tick();
        cpu_set(1'b0, 16'h8000, 8'h00); tick();
        check("pri_cpu_addr", bus.mem_addr, 16'h8000);
        check("pri_cpu_we", bus.mem_we, 0);
        check("pri_wait", bus.dl_wait, 1);
        tick(); tick();
        check("pri_ack", bus.cpu_ack, 1);
        check("pri_dout", bus.cpu_dout, 8'h5A);
        check("pri_we_c4", bus.mem_we, 0);
        tick();
        check("pri_dl_we", bus.mem_we, 1);
        check("pri_dl_addr", bus.mem_addr, 16'h0200);
        check("pri_dl_wdata", bus.mem_wdata, 8'h77);
        check("pri_dl_wait", bus.dl_wait, 0);
        tick();

        // Starvation: CPU every 3 cycles, download forced at starve_cnt = 8 (cycle 9)
        cpu_set(1'b1, 16'h9000, 8'h11); dl_set(16'h0300, 8'hA5); tick();
        check("stv_c1_addr", bus.mem_addr, 16'h9000);
        check("stv_c1_we", bus.mem_we, 1);
        check("stv_c1_wait", bus.dl_wait, 1);
        tick(); tick();
        cpu_set(1'b1, 16'h9001, 8'h22); tick();
        tick(); tick();
        cpu_set(1'b1, 16'h9002, 8'h33); tick();
        tick(); tick();
        check("stv_c9_wait", bus.dl_wait, 1);
        check("stv_c9_we", bus.mem_we, 0);
        check("stv_c9_ack", bus.cpu_ack, 1);
        cpu_set(1'b0, 16'h9000, 8'h00); tick();
        check("stv_dl_we", bus.mem_we, 1);
        check("stv_dl_addr", bus.mem_addr, 16'h0300);
        check("stv_dl_wdata", bus.mem_wdata, 8'hA5);
        check("stv_dl_wait", bus.dl_wait, 0);
        check("stv_c10_ack", bus.cpu_ack, 0);
        tick(); tick();
        check("stv_c12_addr", bus.mem_addr, 16'h9000);
        check("stv_c12_we", bus.mem_we, 0);
        tick();
        check("stv_c13_ack", bus.cpu_ack, 0);
        tick();
        check("stv_c14_ack", bus.cpu_ack, 1);
        check("stv_c14_dout", bus.cpu_dout, 8'h11);
        check("stv_err", bus.err_overrun, 0);

        // Download overrun while held (dropped), then strobe on grant cycle (kept)
        cpu_set(1'b0, 16'h9001, 8'h00); dl_set(16'h0400, 8'h01); tick();
        dl_set(16'h0401, 8'h02); tick();
        check("ovr_wait", bus.dl_wait, 1);
        check("ovr_err", bus.err_overrun, 1);
        tick();
        check("ovr_ack", bus.cpu_ack, 1);
        check("ovr_dout", bus.cpu_dout, 8'h22);
        dl_set(16'h0402, 8'h03); tick();
        check("ovr_dl1_we", bus.mem_we, 1);
        check("ovr_dl1_addr", bus.mem_addr, 16'h0400);
        check("ovr_dl1_wdata", bus.mem_wdata, 8'h01);
        check("ovr_refill_wait", bus.dl_wait, 1);
        tick(); tick();
        check("ovr_dl2_we", bus.mem_we, 1);
        check("ovr_dl2_addr", bus.mem_addr, 16'h0402);
        check("ovr_dl2_wdata", bus.mem_wdata, 8'h03);
        check("ovr_dl2_wait", bus.dl_wait, 0);
        tick();
        cpu_set(1'b0, 16'h0401, 8'h00); tick(); tick(); tick();
        check("ovr_drop_ack", bus.cpu_ack, 1);
        check("ovr_drop_data", bus.cpu_dout, 8'h00);
        check("ovr_sticky", bus.err_overrun, 1);

        // Reset during CPU_ACC of a read with a download held
        cpu_set(1'b0, 16'h8000, 8'h00); dl_set(16'h0500, 8'h55); tick();
        reset = 1'b1; tick();
        check("mrst_ack", bus.cpu_ack, 0);
        check("mrst_dout", bus.cpu_dout, 8'hFF);
        check("mrst_wait", bus.dl_wait, 0);
        check("mrst_we", bus.mem_we, 0);
        check("mrst_addr", bus.mem_addr, 0);
        check("mrst_err", bus.err_overrun, 0);
        reset = 1'b0; tick();
        check("mrst_ack_after", bus.cpu_ack, 0);
        check("mrst_wait_after", bus.dl_wait, 0);
        check("mrst_we_after", bus.mem_we, 0);

        // CPU request during DL_ACC: latched, one cycle late
        dl_set(16'h0600, 8'h66); tick();
        tick();
        check("dla_we", bus.mem_we, 1);
        check("dla_addr", bus.mem_addr, 16'h0600);
        cpu_set(1'b0, 16'h0123, 8'h00); tick();
        check("dla_c3_ack", bus.cpu_ack, 0);
        tick();
        check("dla_cpu_addr", bus.mem_addr, 16'h0123);
        tick();
        check("dla_c5_ack", bus.cpu_ack, 0);
        tick();
        check("dla_c6_ack", bus.cpu_ack, 1);
        check("dla_dout", bus.cpu_dout, 8'hC3);
        check("dla_err", bus.err_overrun, 0);

        // CPU request while an access is in flight: ignored, overrun flagged
        cpu_set(1'b1, 16'h8001, 8'h44); tick();
        check("cov_err_c1", bus.err_overrun, 0);
        cpu_set(1'b0, 16'h7777, 8'h00); tick();
        check("cov_err_c2", bus.err_overrun, 1);
        tick();
        check("cov_ack", bus.cpu_ack, 1);
        tick();
        check("cov_ack_c4", bus.cpu_ack, 0);
        tick();
        check("cov_ack_c5", bus.cpu_ack, 0);
        check("cov_addr_c5", bus.mem_addr, 16'h8001);
        check("cov_sticky", bus.err_overrun, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
